// File: rtl/reset_recovery_ctrl.sv
// Reset stretcher and recovery sequencer fed by a one-cycle edge-detect pulse.
// Optional feature: define RESET_RETRIGGER_EN so a pulse during the hold phase restarts the hold.
module reset_recovery_ctrl #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned RECOVER_CYCLES = 8,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             detected,
    output logic             detect_enable,
    output logic             reset_out,
    output logic             ready,
    output logic             busy,
    output logic [CNT_W-1:0] event_count
);

    localparam int unsigned MaxCycles =
        (HOLD_CYCLES > RECOVER_CYCLES) ? HOLD_CYCLES : RECOVER_CYCLES;
    localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0]  HoldLast    = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0]  RecoverLast = CntW'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CountMax    = {CNT_W{1'b1}};

`ifdef RESET_RETRIGGER_EN
    localparam logic RetriggerEn = 1'b1;
`else
    localparam logic RetriggerEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StRecover
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  evt_q, evt_d;

    logic reset_out_q, reset_out_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic detect_enable_q, detect_enable_d;

    // Outputs are flopped from the decoded next state, so they line up with state_q.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= StAssert;
            cnt_q           <= '0;
            evt_q           <= '0;
            reset_out_q     <= 1'b1;
            ready_q         <= 1'b0;
            busy_q          <= 1'b1;
            detect_enable_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            evt_q           <= evt_d;
            reset_out_q     <= reset_out_d;
            ready_q         <= ready_d;
            busy_q          <= busy_d;
            detect_enable_q <= detect_enable_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = evt_q;
        unique case (state_q)
            StIdle: begin
                if (detected) begin
                    state_d = StAssert;
                    cnt_d   = '0;
                    if (evt_q != CountMax) begin
                        evt_d = evt_q + 1'b1;
                    end
                end
            end
            StAssert: begin
                // A retrigger wins over the hold-complete transition.
                if (RetriggerEn && detected) begin
                    cnt_d = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRecover;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRecover: begin
                if (cnt_q == RecoverLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StAssert;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        reset_out_d     = 1'b1;
        ready_d         = 1'b0;
        busy_d          = 1'b1;
        detect_enable_d = 1'b0;
        unique case (state_d)
            StIdle: begin
                reset_out_d     = 1'b0;
                ready_d         = 1'b1;
                busy_d          = 1'b0;
                detect_enable_d = 1'b1;
            end
            StAssert: begin
                detect_enable_d = RetriggerEn;
            end
            StRecover: begin
                reset_out_d = 1'b0;
            end
            default: begin
                reset_out_d = 1'b1;
            end
        endcase
    end

    assign reset_out     = reset_out_q;
    assign ready         = ready_q;
    assign busy          = busy_q;
    assign detect_enable = detect_enable_q;
    assign event_count   = evt_q;

endmodule

// File: tb/tb_reset_recovery_ctrl.sv
// Directed bench for reset_recovery_ctrl; expectations follow RESET_RETRIGGER_EN when defined.
module tb_reset_recovery_ctrl;

    localparam int Hold = 16;
    localparam int Rec  = 8;

`ifdef RESET_RETRIGGER_EN
    localparam bit Retrig = 1'b1;
`else
    localparam bit Retrig = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       detected = 1'b0;
    logic       detected2 = 1'b0;
    logic       detect_enable, reset_out, ready, busy;
    logic [7:0] event_count;
    logic       detect_enable2, reset_out2, ready2, busy2;
    logic [1:0] event_count2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reset_recovery_ctrl #(
        .HOLD_CYCLES   (Hold),
        .RECOVER_CYCLES(Rec),
        .CNT_W         (8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .detected     (detected),
        .detect_enable(detect_enable),
        .reset_out    (reset_out),
        .ready        (ready),
        .busy         (busy),
        .event_count  (event_count)
    );

    reset_recovery_ctrl #(
        .HOLD_CYCLES   (3),
        .RECOVER_CYCLES(2),
        .CNT_W         (2)
    ) dut_sat (
        .CLK          (CLK),
        .RST          (RST),
        .detected     (detected2),
        .detect_enable(detect_enable2),
        .reset_out    (reset_out2),
        .ready        (ready2),
        .busy         (busy2),
        .event_count  (event_count2)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse;
        detected = 1'b1;
        tick();
        detected = 1'b0;
    endtask

    // Walks one sequence from the edge after the trigger until ready, counting outputs;
    // optionally drives detected into the edge following sample index inj.
    task automatic run_seq(input int inj, output int h, output int nr, output int dl);
        h = 0;
        nr = 0;
        dl = 0;
        for (int i = 0; i < 200; i++) begin
            if (reset_out) h++;
            if (!ready) nr++;
            if (!detect_enable) dl++;
            if (ready) break;
            detected = (i == inj);
            tick();
            detected = 1'b0;
        end
    endtask

    task automatic test_reset;
        int n;
        #2;
        RST = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if (reset_out !== 1'b1) $display("FAIL por_reset_out: got %b want 1", reset_out);
        else pass_cnt++;
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL por_ready: got %b want 0", ready);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL por_busy: got %b want 1", busy);
        else pass_cnt++;
        total_cnt++;
        if (detect_enable !== 1'b0) $display("FAIL por_den: got %b want 0", detect_enable);
        else pass_cnt++;
        total_cnt++;
        if (event_count !== 8'd0) $display("FAIL por_evt: got %0d want 0", event_count);
        else pass_cnt++;
        RST = 1'b0;
        n = 0;
        while (reset_out && n < 200) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n !== Hold) $display("FAIL por_hold_len: got %0d want %0d", n, Hold);
        else pass_cnt++;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n !== Hold + Rec) $display("FAIL por_ready_edge: got %0d want %0d", n, Hold + Rec);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || detect_enable !== 1'b1)
            $display("FAIL por_idle: got busy=%b den=%b want 0/1", busy, detect_enable);
        else pass_cnt++;
        total_cnt++;
        if (event_count !== 8'd0) $display("FAIL por_evt_after: got %0d want 0", event_count);
        else pass_cnt++;
    endtask

    task automatic test_single_pulse;
        int h, nr, dl;
        pulse();
        total_cnt++;
        if (event_count !== 8'd1) $display("FAIL single_evt_edge: got %0d want 1", event_count);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1 || detect_enable !== Retrig)
            $display("FAIL single_assert: got busy=%b den=%b want 1/%b", busy, detect_enable, Retrig);
        else pass_cnt++;
        run_seq(-1, h, nr, dl);
        total_cnt++;
        if (h !== Hold) $display("FAIL single_hold: got %0d want %0d", h, Hold);
        else pass_cnt++;
        total_cnt++;
        if (nr !== Hold + Rec) $display("FAIL single_notready: got %0d want %0d", nr, Hold + Rec);
        else pass_cnt++;
        total_cnt++;
        if (dl !== (Retrig ? Rec : Hold + Rec))
            $display("FAIL single_den_low: got %0d want %0d", dl, Retrig ? Rec : Hold + Rec);
        else pass_cnt++;
        total_cnt++;
        if (event_count !== 8'd1) $display("FAIL single_evt: got %0d want 1", event_count);
        else pass_cnt++;
    endtask

    task automatic test_hold_pulse;
        int h, nr, dl;
        pulse();
        run_seq(10, h, nr, dl);
        total_cnt++;
        if (h !== (Retrig ? 27 : Hold))
            $display("FAIL hold_pulse_len: got %0d want %0d", h, Retrig ? 27 : Hold);
        else pass_cnt++;
        total_cnt++;
        if (nr !== (Retrig ? 27 + Rec : Hold + Rec))
            $display("FAIL hold_pulse_notready: got %0d want %0d", nr, Retrig ? 27 + Rec : Hold + Rec);
        else pass_cnt++;
        total_cnt++;
        if (event_count !== 8'd2) $display("FAIL hold_pulse_evt: got %0d want 2", event_count);
        else pass_cnt++;
    endtask

    task automatic test_recover_pulse;
        int h, nr, dl;
        pulse();
        run_seq(Hold + 2, h, nr, dl);
        total_cnt++;
        if (h !== Hold) $display("FAIL recover_pulse_hold: got %0d want %0d", h, Hold);
        else pass_cnt++;
        total_cnt++;
        if (nr !== Hold + Rec)
            $display("FAIL recover_pulse_notready: got %0d want %0d", nr, Hold + Rec);
        else pass_cnt++;
        total_cnt++;
        if (event_count !== 8'd3) $display("FAIL recover_pulse_evt: got %0d want 3", event_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int h, nr, dl;
        pulse();
        // Pulse lands on the final recover edge, which must not retrigger.
        run_seq(Hold + Rec - 1, h, nr, dl);
        total_cnt++;
        if (nr !== Hold + Rec) $display("FAIL entry_pulse_notready: got %0d want %0d", nr, Hold + Rec);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL entry_pulse_idle: got ready=%b busy=%b want 1/0", ready, busy);
        else pass_cnt++;
        total_cnt++;
        if (event_count !== 8'd4) $display("FAIL entry_pulse_evt: got %0d want 4", event_count);
        else pass_cnt++;
        pulse();
        total_cnt++;
        if (reset_out !== 1'b1 || event_count !== 8'd5)
            $display("FAIL b2b_accept: got rst=%b evt=%0d want 1/5", reset_out, event_count);
        else pass_cnt++;
        run_seq(-1, h, nr, dl);
        total_cnt++;
        if (h !== Hold) $display("FAIL b2b_hold: got %0d want %0d", h, Hold);
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        int sat_exp[5];
        int n;
        sat_exp = '{1, 2, 3, 3, 3};
        for (int e = 0; e < 5; e++) begin
            detected2 = 1'b1;
            tick();
            detected2 = 1'b0;
            total_cnt++;
            if (event_count2 !== 2'(sat_exp[e]))
                $display("FAIL sat_evt_%0d: got %0d want %0d", e, event_count2, sat_exp[e]);
            else pass_cnt++;
            total_cnt++;
            if (reset_out2 !== 1'b1 || busy2 !== 1'b1 || detect_enable2 !== Retrig)
                $display("FAIL sat_assert_%0d: got rst=%b busy=%b den=%b", e, reset_out2, busy2,
                         detect_enable2);
            else pass_cnt++;
            n = 0;
            while (!ready2 && n < 50) begin
                tick();
                n++;
            end
            total_cnt++;
            if (n !== 5) $display("FAIL sat_seq_len_%0d: got %0d want 5", e, n);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset;
        int n;
        pulse();
        total_cnt++;
        if (event_count !== 8'd6) $display("FAIL mid_pre_evt: got %0d want 6", event_count);
        else pass_cnt++;
        repeat (Hold + 4) tick();
        total_cnt++;
        if (reset_out !== 1'b0 || ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL mid_in_recover: got rst=%b rdy=%b busy=%b want 0/0/1", reset_out, ready,
                     busy);
        else pass_cnt++;
        RST = 1'b1;
        #1;
        total_cnt++;
        if (reset_out !== 1'b1 || ready !== 1'b0 || busy !== 1'b1 || detect_enable !== 1'b0)
            $display("FAIL mid_async: got rst=%b rdy=%b busy=%b den=%b want 1/0/1/0", reset_out,
                     ready, busy, detect_enable);
        else pass_cnt++;
        total_cnt++;
        if (event_count !== 8'd0) $display("FAIL mid_async_evt: got %0d want 0", event_count);
        else pass_cnt++;
        repeat (2) tick();
        RST = 1'b0;
        n = 0;
        while (reset_out && n < 200) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n !== Hold) $display("FAIL mid_hold_len: got %0d want %0d", n, Hold);
        else pass_cnt++;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n !== Hold + Rec) $display("FAIL mid_ready_edge: got %0d want %0d", n, Hold + Rec);
        else pass_cnt++;
        total_cnt++;
        if (event_count !== 8'd0) $display("FAIL mid_evt_after: got %0d want 0", event_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_hold_pulse();
        test_recover_pulse();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
